// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and a helper that slices one field out of a
// packed multi-port bus.
package cpu_pkg;

  localparam int REG_ADDR_W  = 5;
  localparam int REG_DATA_W  = 32;
  localparam int SEL_BUS_W   = 128;
  localparam int SEL_FIELD_W = 64;

  function automatic logic [SEL_FIELD_W-1:0] sel_field(input logic [SEL_BUS_W-1:0] bus,
                                                       input int idx,
                                                       input int w);
    logic [SEL_BUS_W-1:0] sh;
    sh = bus >> (idx * w);
    return SEL_FIELD_W'(sh) & ((SEL_FIELD_W'(1) << w) - SEL_FIELD_W'(1));
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard: one bit per register plus a registered population count that
// is updated incrementally from the bits that change each cycle.
module regfile_scoreboard
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   wr0_en,
  input  logic [ADDR_W-1:0]      wr0_num,
  input  logic                   wr1_en,
  input  logic [ADDR_W-1:0]      wr1_num,
  input  logic                   issue_en,
  input  logic [ADDR_W-1:0]      issue_num,
  input  logic                   flush,
  output logic [(1<<ADDR_W)-1:0] busy,
  output logic [ADDR_W:0]        busy_cnt
);

  localparam int NREG = 1 << ADDR_W;

  logic [NREG-1:0] busy_q, busy_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic [ADDR_W:0] n_set, n_clr;
  logic            iss_ok;

  assign iss_ok = issue_en && ((ZERO_REG == 0) || (issue_num != '0));

  // Priority per bit: flush clears, then a new producer sets, then a write clears.
  always_comb begin
    busy_d = busy_q;
    n_set  = '0;
    n_clr  = '0;
    for (int r = 0; r < NREG; r++) begin
      if (flush)
        busy_d[r] = 1'b0;
      else if (iss_ok && (issue_num == ADDR_W'(r)))
        busy_d[r] = 1'b1;
      else if ((wr0_en && (wr0_num == ADDR_W'(r))) || (wr1_en && (wr1_num == ADDR_W'(r))))
        busy_d[r] = 1'b0;
    end
    for (int r = 0; r < NREG; r++) begin
      if (busy_d[r] && !busy_q[r]) n_set = n_set + (ADDR_W+1)'(1);
      if (!busy_d[r] && busy_q[r]) n_clr = n_clr + (ADDR_W+1)'(1);
    end
    cnt_d = flush ? '0 : (cnt_q + n_set - n_clr);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy     = busy_q;
  assign busy_cnt = cnt_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with two prioritised write ports, optional
// write-to-read bypass, optional hard-wired zero register and busy scoreboard.
module regfile_mp_sb
  import cpu_pkg::*;
#(
  parameter int DATA_W   = REG_DATA_W,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [NRD*ADDR_W-1:0] R_Num,
  output logic [NRD*DATA_W-1:0] R_Value,
  output logic [NRD-1:0]        R_Busy,
  input  logic                  WE0,
  input  logic [ADDR_W-1:0]     W0_Num,
  input  logic [DATA_W-1:0]     Din0,
  input  logic                  WE1,
  input  logic [ADDR_W-1:0]     W1_Num,
  input  logic [DATA_W-1:0]     Din1,
  input  logic                  Issue_En,
  input  logic [ADDR_W-1:0]     Issue_Num,
  input  logic                  Flush,
  output logic [ADDR_W:0]       Busy_Cnt
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [NREG];
  logic [DATA_W-1:0] mem_d [NREG];
  logic [NREG-1:0]   busy_vec;
  logic              we0_ok, we1_ok;

  assign we0_ok = WE0 && ((ZERO_REG == 0) || (W0_Num != '0));
  assign we1_ok = WE1 && ((ZERO_REG == 0) || (W1_Num != '0));

  // Port 1 is applied last so it wins a same-register collision.
  always_comb begin
    mem_d = mem_q;
    if (we0_ok) mem_d[W0_Num] = Din0;
    if (we1_ok) mem_d[W1_Num] = Din1;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .Clk       (Clk),
    .Rst       (Rst),
    .wr0_en    (we0_ok),
    .wr0_num   (W0_Num),
    .wr1_en    (we1_ok),
    .wr1_num   (W1_Num),
    .issue_en  (Issue_En),
    .issue_num (Issue_Num),
    .flush     (Flush),
    .busy      (busy_vec),
    .busy_cnt  (Busy_Cnt)
  );

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] rn;
    logic [DATA_W-1:0] val;
    logic              bsy;

    assign rn = ADDR_W'(sel_field(SEL_BUS_W'(R_Num), k, ADDR_W));

    // A matching write in flight means its producer has completed: forward data, not busy.
    always_comb begin
      val = mem_q[rn];
      bsy = busy_vec[rn];
      if (BYPASS != 0) begin
        if (we0_ok && (W0_Num == rn)) begin
          val = Din0;
          bsy = 1'b0;
        end
        if (we1_ok && (W1_Num == rn)) begin
          val = Din1;
          bsy = 1'b0;
        end
      end
      if ((ZERO_REG != 0) && (rn == '0)) begin
        val = '0;
        bsy = 1'b0;
      end
    end

    assign R_Value[k*DATA_W +: DATA_W] = val;
    assign R_Busy[k]                   = bsy;
  end

endmodule
